// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
// Parametrised pipeline stage register for the RISC-V datapath. One
// instance sits at each pipeline boundary (F/D, D/E, E/M, M/W) and carries
// a payload word plus a control bundle under a valid/ready handshake.
// It also obeys stall/flush from the hazard unit and keeps two saturating
// performance counters.
//
// Parameters
//   DATA_W  payload width (instr, PC, operands, imm, ...)
//   CTRL_W  control bundle width (RegWrite, MemWrite, ResultSrc, ...)
//   SKID    0 = single register with combinational in_ready,
//           1 = 2-entry skid buffer with registered in_ready
//   CNT_W   width of each performance counter
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   in_valid   upstream offers an entry
//   in_ready   stage accepts the entry this cycle (0 while rst is high)
//   in_data    upstream payload
//   in_ctrl    upstream control bundle
//   out_valid  stage holds a valid entry
//   out_ready  downstream accepts the entry this cycle
//   out_data   registered payload (holds its value when emptied)
//   out_ctrl   registered control bundle, all zero when out_valid is 0
//   stall      hazard unit: freeze this stage
//   flush      hazard unit: kill all contents
//   cnt_clr    synchronous clear of both counters
//   stall_cnt  cycles with stall high while holding a valid entry
//   flush_cnt  flushes that actually killed at least one entry

module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int SKID   = 0,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              stall,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // Handshake terms shared by both buffer flavours. A stalled stage never
  // hands its entry downstream, regardless of out_ready.
  logic drain;
  logic out_fire;
  logic in_fire;
  logic skid_valid;

  assign drain    = out_ready & ~stall;
  assign out_fire = out_valid & drain;
  assign in_fire  = in_valid & in_ready;

  generate
    if (SKID == 0) begin : g_single

      // Ready whenever the register is empty or being emptied this cycle;
      // stall freezes the stage so nothing may enter either.
      assign in_ready   = ~rst & ~stall & (~out_valid | out_ready);
      assign skid_valid = 1'b0;

      // Single register: a new entry always wins over a drain because the
      // drained slot is refilled on the same edge. Flush kills the entry
      // but leaves out_data alone since it is meaningless while invalid.
      always_ff @(posedge clk) begin
        if (rst) begin
          out_valid <= 1'b0;
          out_data  <= '0;
          out_ctrl  <= '0;
        end else if (flush) begin
          out_valid <= 1'b0;
          out_ctrl  <= '0;
        end else if (in_fire) begin
          out_valid <= 1'b1;
          out_data  <= in_data;
          out_ctrl  <= in_ctrl;
        end else if (out_fire) begin
          out_valid <= 1'b0;
          out_ctrl  <= '0;
        end
      end

    end else begin : g_skid

      typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
      } state_t;

      state_t            state;
      logic              ready_q;
      logic [DATA_W-1:0] skid_data;
      logic [CTRL_W-1:0] skid_ctrl;

      // ready_q is a pure register, so upstream timing never sees
      // out_ready or stall; only the synchronous reset gates it.
      assign in_ready   = ready_q & ~rst;
      assign skid_valid = (state == TWO);

      // Two-entry FIFO: the main register (out_*) is always the oldest
      // entry, the skid register holds the younger one. ready_q tracks
      // "not full" one cycle ahead so it can be registered. Because the
      // stage only advertises ready when a slot is free, an entry can keep
      // filling EMPTY/ONE while stalled; the stall only blocks the drain.
      always_ff @(posedge clk) begin
        if (rst) begin
          state     <= EMPTY;
          ready_q   <= 1'b1;
          out_valid <= 1'b0;
          out_data  <= '0;
          out_ctrl  <= '0;
          skid_data <= '0;
          skid_ctrl <= '0;
        end else if (flush) begin
          state     <= EMPTY;
          ready_q   <= 1'b1;
          out_valid <= 1'b0;
          out_ctrl  <= '0;
        end else begin
          case (state)
            EMPTY: begin
              if (in_fire) begin
                state     <= ONE;
                out_valid <= 1'b1;
                out_data  <= in_data;
                out_ctrl  <= in_ctrl;
              end
            end
            ONE: begin
              if (in_fire && !out_fire) begin
                state     <= TWO;
                ready_q   <= 1'b0;
                skid_data <= in_data;
                skid_ctrl <= in_ctrl;
              end else if (out_fire && !in_fire) begin
                state     <= EMPTY;
                out_valid <= 1'b0;
                out_ctrl  <= '0;
              end else if (out_fire && in_fire) begin
                out_data <= in_data;
                out_ctrl <= in_ctrl;
              end
            end
            TWO: begin
              if (out_fire) begin
                state    <= ONE;
                ready_q  <= 1'b1;
                out_data <= skid_data;
                out_ctrl <= skid_ctrl;
              end
            end
            default: begin
              state     <= EMPTY;
              ready_q   <= 1'b1;
              out_valid <= 1'b0;
              out_ctrl  <= '0;
            end
          endcase
        end
      end

    end
  endgenerate

  // Counter increment conditions. A stall cycle only counts when there is
  // something being held and the flush is not wiping it in the same cycle.
  // A flush only counts when it destroys something, including an entry
  // that was being accepted on that very cycle.
  logic stall_inc;
  logic flush_inc;

  assign stall_inc = stall & out_valid & ~flush;
  assign flush_inc = flush & (out_valid | skid_valid | in_fire);

  // Saturating counters; cnt_clr beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (flush_inc && (flush_cnt != {CNT_W{1'b1}})) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule
